vga_bar_display: RTL
====================

// Module: vga_bar_display
// PURPOSE
//  Parametrised VGA raster generator with N vertical level bars driven by per-channel sample values.
//  Generates hsync/vsync and registered RGB from one pixel clock.
//  Two colour modes: threshold (solid bar, green/blue) or fill (bar height proportional to value).
//  Bar values and mode are captured once per frame, so no tearing.
//  Sits between the segmentation datapath (sum outputs) and the board VGA connector.
// PARAMETERS
//  H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48 (H_TOTAL = 800)
//  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 29 (V_TOTAL = 521)
//  SYNC_POL 0   sync asserted level (0 = active-low)
//  NUM_BARS 6   bar channels, 1..16
//  BAR_X0 50, BAR_Y0 150 top-left of bar 0, in active-area coordinates
//  BAR_W 75, BAR_GAP 15, BAR_H 150 bar geometry in pixels
//  VAL_W 11     width of each bar value
//  THRESH 675   threshold-mode compare constant
//  COLOR_W 4    bits per colour channel
// PORTS
//  dclk         in   1                   pixel clock, 25 MHz
//  clr_n        in   1                   async active-low reset
//  bar_val      in   NUM_BARS*VAL_W      channel i at [i*VAL_W +: VAL_W]
//  bar_en       in   NUM_BARS            per-bar enable; disabled bar draws black
//  mode         in   1                   0 = threshold, 1 = fill
//  hsync        out  1                   horizontal sync
//  vsync        out  1                   vertical sync
//  red/green/blue out COLOR_W            pixel colour
//  active       out  1                   pixel is in visible area
//  pix_x        out  clog2(H_ACTIVE)     active-area x; 0 when not active
//  pix_y        out  clog2(V_ACTIVE)     active-area y; 0 when not active
//  frame_start  out  1                   one-cycle pulse at counter (0,0)
// BEHAVIOUR
//  Counters and line order
//   - hc counts 0..H_TOTAL-1; at wrap it returns to 0 and vc increments.
//   - vc counts 0..V_TOTAL-1, then wraps to 0.
//   - Line order: sync, back porch, active, front porch.
//     h sync when hc < H_SYNC; h active when H_SYNC+H_BP <= hc < H_SYNC+H_BP+H_ACTIVE.
//     Vertical uses the same order.
//  Output registering and latency
//   - Every output is registered, with one cycle of latency from the counter state.
//   - Syncs, colour, active and coordinates stay mutually aligned.
//  Reset (clr_n low, async, also mid-frame)
//   - hc = vc = 0.
//   - hsync and vsync = !SYNC_POL (deasserted); RGB = 0; active = 0; pix_x = pix_y = 0; frame_start = 0.
//   - Shadow values = 0; shadow mode = 0.
//   - After release, counting starts at (0,0) and frame_start pulses on the first output cycle.
//  Per-frame capture
//   - On the cycle where hc = H_TOTAL-1 and vc = V_TOTAL-1, capture bar_val, bar_en and mode into shadow registers.
//   - Input changes at any other time have no effect until that cycle.
//  Bar geometry
//   - Bar i covers x in [BAR_X0 + i*(BAR_W+BAR_GAP), +BAR_W) and y in [BAR_Y0, BAR_Y0+BAR_H).
//  Pixel colour (active area only)
//   - Pixel outside every bar, or bar disabled: black.
//   - Threshold mode, value > THRESH (strictly greater): green full-scale (all ones). Otherwise blue full-scale.
//   - Fill mode: lit = min(value, BAR_H) rows, counted up from the bottom row y = BAR_Y0+BAR_H-1.
//     Pixel is drawn in the threshold colour if (BAR_Y0+BAR_H-1-y) < lit, else black.
//     value 0 means no rows lit; value >= BAR_H means the full bar.
//  Blanking: RGB forced to 0 whenever not active.
//  Elaboration errors (fatal)
//   - BAR_X0 + NUM_BARS*BAR_W + (NUM_BARS-1)*BAR_GAP > H_ACTIVE
//   - BAR_Y0 + BAR_H > V_ACTIVE
//   - NUM_BARS = 0
//  Arithmetic: comparisons are unsigned; counter width = clog2(total).
// STRUCTURE
//  Package vga_pkg holds:
//   - the 640x480@60 timing constants, used as parameter defaults
//   - typedef rgb_t {r,g,b}
//   - the colour constants BLACK, GREEN, BLUE
//  Sub-module vga_timing holds the counters, the sync/active decode and the frame_start tick.
//  The top level holds the shadow registers, the bar hit and colour logic, and the output registers.
// TESTING
//  1. Reset: clr_n low mid-line -> same cycle: hsync = vsync = 1, RGB = 0, active = 0. Release -> frame_start = 1 for exactly 1 cycle.
//  2. Timing: free run 2 frames -> hsync low for 96 of every 800 cycles; vsync low for 1600 of every 416800 cycles; 640 active pixels per active line.
//  3. Threshold: mode = 0, bar0 = 676 -> pixel (x=50, y=150) green = F, blue = 0. bar0 = 675 -> blue = F. Pixel (x=125, y=150) is black (gap).
//  4. Frame capture: change bar1 from 100 to 700 mid-frame -> rest of that frame stays blue. Next frame after frame_start -> green.
//  5. Fill: mode = 1, bar2 = 10 -> rows y = 290..299 lit and rows y = 150..289 black. bar2 = 2047 -> all 150 rows lit.
//  6. Enable and blank: bar_en[3] = 0 -> bar 3 region is black. Pixels in the porches always have RGB = 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60) and colour types for the bar display.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 32'd640;
    localparam int H_FP_DEF     = 32'd16;
    localparam int H_SYNC_DEF   = 32'd96;
    localparam int H_BP_DEF     = 32'd48;
    localparam int V_ACTIVE_DEF = 32'd480;
    localparam int V_FP_DEF     = 32'd10;
    localparam int V_SYNC_DEF   = 32'd2;
    localparam int V_BP_DEF     = 32'd29;

    localparam int RGB_W = 32'd4;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    localparam rgb_t BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
    localparam rgb_t GREEN = '{r: 4'h0, g: 4'hF, b: 4'h0};
    localparam rgb_t BLUE  = '{r: 4'h0, g: 4'h0, b: 4'hF};

endpackage

// File: rtl/vga_bar_display_if.sv
// Bar-value inputs and VGA raster outputs of the bar display.
// master = sample producer / monitor side, slave = the display itself.
interface vga_bar_display_if #(
    parameter int NUM_BARS = 32'd6,
    parameter int VAL_W    = 32'd11,
    parameter int COLOR_W  = 32'd4,
    parameter int X_W      = 32'd10,
    parameter int Y_W      = 32'd9
);
    logic [NUM_BARS*VAL_W-1:0] bar_val;
    logic [NUM_BARS-1:0]       bar_en;
    logic                      mode;
    logic                      hsync;
    logic                      vsync;
    logic [COLOR_W-1:0]        red;
    logic [COLOR_W-1:0]        green;
    logic [COLOR_W-1:0]        blue;
    logic                      active;
    logic [X_W-1:0]            pix_x;
    logic [Y_W-1:0]            pix_y;
    logic                      frame_start;

    modport master (
        output bar_val, bar_en, mode,
        input  hsync, vsync, red, green, blue, active, pix_x, pix_y, frame_start
    );

    modport slave (
        input  bar_val, bar_en, mode,
        output hsync, vsync, red, green, blue, active, pix_x, pix_y, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// Raster counters plus combinational sync/active/coordinate decode of the
// current counter state. Line order: sync, back porch, active, front porch.
module vga_timing #(
    parameter int H_ACTIVE = 32'd640,
    parameter int H_FP     = 32'd16,
    parameter int H_SYNC   = 32'd96,
    parameter int H_BP     = 32'd48,
    parameter int V_ACTIVE = 32'd480,
    parameter int V_FP     = 32'd10,
    parameter int V_SYNC   = 32'd2,
    parameter int V_BP     = 32'd29,
    parameter bit SYNC_POL = 1'b0,
    localparam int X_W     = $clog2(H_ACTIVE),
    localparam int Y_W     = $clog2(V_ACTIVE)
) (
    input  logic           dclk_i,
    input  logic           clr_ni,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           active_o,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           frame_tick_o,
    output logic           frame_end_o
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(H_TOTAL - 32'd1);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_SYNC);
    localparam logic [HC_W-1:0] HA_START = HC_W'(H_SYNC + H_BP);
    localparam logic [HC_W-1:0] HA_END   = HC_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [HC_W-1:0] HC_ONE   = HC_W'(32'd1);
    localparam logic [VC_W-1:0] VC_LAST  = VC_W'(V_TOTAL - 32'd1);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_SYNC);
    localparam logic [VC_W-1:0] VA_START = VC_W'(V_SYNC + V_BP);
    localparam logic [VC_W-1:0] VA_END   = VC_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [VC_W-1:0] VC_ONE   = VC_W'(32'd1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic [VC_W-1:0] vc_q, vc_d;
    logic            h_act_s, v_act_s;

    // Next counter state: hc wraps at end of line and bumps vc, vc wraps at end of frame.
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (hc_q == HC_LAST) begin
            hc_d = '0;
            if (vc_q == VC_LAST) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + VC_ONE;
            end
        end else begin
            hc_d = hc_q + HC_ONE;
        end
    end

    // Counter registers; reset restarts the raster at (0,0).
    always_ff @(posedge dclk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Decode of the current counter state; the top registers all of it together.
    always_comb begin
        h_act_s      = (hc_q >= HA_START) && (hc_q < HA_END);
        v_act_s      = (vc_q >= VA_START) && (vc_q < VA_END);
        hsync_o      = (hc_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync_o      = (vc_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        active_o     = h_act_s && v_act_s;
        frame_tick_o = (hc_q == '0) && (vc_q == '0);
        frame_end_o  = (hc_q == HC_LAST) && (vc_q == VC_LAST);
        if (active_o) begin
            x_o = X_W'(hc_q - HA_START);
            y_o = Y_W'(vc_q - VA_START);
        end else begin
            x_o = '0;
            y_o = '0;
        end
    end
endmodule

// File: rtl/vga_bar_display.sv
// VGA raster generator drawing NUM_BARS vertical level bars. Bar inputs are
// sampled once per frame (last pixel of the frame) so a frame never tears.
module vga_bar_display
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int NUM_BARS = 32'd6,
    parameter int BAR_X0   = 32'd50,
    parameter int BAR_Y0   = 32'd150,
    parameter int BAR_W    = 32'd75,
    parameter int BAR_GAP  = 32'd15,
    parameter int BAR_H    = 32'd150,
    parameter int VAL_W    = 32'd11,
    parameter int THRESH   = 32'd675,
    parameter int COLOR_W  = RGB_W,
    localparam int X_W     = $clog2(H_ACTIVE),
    localparam int Y_W     = $clog2(V_ACTIVE)
) (
    input logic              dclk,
    input logic              clr_n,
    vga_bar_display_if.slave vif
);
    if ((NUM_BARS < 32'sd1) || (NUM_BARS > 32'sd16)) begin : g_chk_num
        $fatal(1, "vga_bar_display: NUM_BARS must be in 1..16");
    end
    if (BAR_X0 + NUM_BARS*BAR_W + (NUM_BARS - 32'sd1)*BAR_GAP > H_ACTIVE) begin : g_chk_x
        $fatal(1, "vga_bar_display: bars do not fit horizontally");
    end
    if (BAR_Y0 + BAR_H > V_ACTIVE) begin : g_chk_y
        $fatal(1, "vga_bar_display: bars do not fit vertically");
    end
    if (COLOR_W != RGB_W) begin : g_chk_color
        $fatal(1, "vga_bar_display: COLOR_W must match vga_pkg::RGB_W");
    end

    logic           hsync_s, vsync_s, active_s, frame_tick_s, frame_end_s;
    logic [X_W-1:0] x_s;
    logic [Y_W-1:0] y_s;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .dclk_i      (dclk),
        .clr_ni      (clr_n),
        .hsync_o     (hsync_s),
        .vsync_o     (vsync_s),
        .active_o    (active_s),
        .x_o         (x_s),
        .y_o         (y_s),
        .frame_tick_o(frame_tick_s),
        .frame_end_o (frame_end_s)
    );

    logic [NUM_BARS*VAL_W-1:0] val_q, val_d;
    logic [NUM_BARS-1:0]       en_q, en_d;
    logic                      mode_q, mode_d;

    // Shadow next state: take new inputs only on the final cycle of the frame.
    always_comb begin
        if (frame_end_s) begin
            val_d  = vif.bar_val;
            en_d   = vif.bar_en;
            mode_d = vif.mode;
        end else begin
            val_d  = val_q;
            en_d   = en_q;
            mode_d = mode_q;
        end
    end

    logic [31:0]      x32_s, y32_s, val32_s, lit_s, row_s;
    logic             hit_s, in_rows_s, lit_row_s, green_s;
    logic [VAL_W-1:0] hit_val_s;
    rgb_t             pix_s;

    // Horizontal hit test: which enabled bar (bars never overlap) covers this column.
    always_comb begin
        x32_s     = 32'(x_s);
        hit_s     = 1'b0;
        hit_val_s = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if (en_q[i] && (x32_s >= 32'(BAR_X0 + i*(BAR_W + BAR_GAP)))
                        && (x32_s <  32'(BAR_X0 + i*(BAR_W + BAR_GAP) + BAR_W))) begin
                hit_s     = 1'b1;
                hit_val_s = val_q[i*VAL_W +: VAL_W];
            end else begin
                hit_s     = hit_s;
                hit_val_s = hit_val_s;
            end
        end
    end

    // Pixel colour: threshold picks green/blue; fill mode lights rows from the bottom up.
    always_comb begin
        y32_s     = 32'(y_s);
        val32_s   = 32'(hit_val_s);
        in_rows_s = (y32_s >= 32'(BAR_Y0)) && (y32_s < 32'(BAR_Y0 + BAR_H));
        row_s     = 32'(BAR_Y0 + BAR_H - 32'sd1) - y32_s;
        lit_s     = (val32_s > 32'(BAR_H)) ? 32'(BAR_H) : val32_s;
        green_s   = val32_s > 32'(THRESH);
        if (mode_q) begin
            lit_row_s = row_s < lit_s;
        end else begin
            lit_row_s = 1'b1;
        end
        if (active_s && hit_s && in_rows_s && lit_row_s) begin
            pix_s = green_s ? GREEN : BLUE;
        end else begin
            pix_s = BLACK;
        end
    end

    logic           hsync_q, vsync_q, active_q, frame_q;
    logic [X_W-1:0] pix_x_q;
    logic [Y_W-1:0] pix_y_q;
    rgb_t           rgb_q;

    // Shadow and output registers; all outputs carry one cycle of latency together.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            val_q    <= '0;
            en_q     <= '0;
            mode_q   <= 1'b0;
            hsync_q  <= ~SYNC_POL;
            vsync_q  <= ~SYNC_POL;
            active_q <= 1'b0;
            frame_q  <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            rgb_q    <= BLACK;
        end else begin
            val_q    <= val_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            hsync_q  <= hsync_s;
            vsync_q  <= vsync_s;
            active_q <= active_s;
            frame_q  <= frame_tick_s;
            pix_x_q  <= x_s;
            pix_y_q  <= y_s;
            rgb_q    <= pix_s;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.active      = active_q;
    assign vif.frame_start = frame_q;
    assign vif.pix_x       = pix_x_q;
    assign vif.pix_y       = pix_y_q;
    assign vif.red         = rgb_q.r;
    assign vif.green       = rgb_q.g;
    assign vif.blue        = rgb_q.b;
endmodule
